uart_tx_ctl: RTL and testbench

Serial transmit controller for the UART link. Accepts 8-bit characters through a valid/acknowledge handshake, serialises each one as an 8N1 frame on `txd_tx`, and reports busy status. It is the transmit counterpart of the receive path that delivers `rx_data`/`rx_data_rdy` to the LED logic. It sits between the character source (echo/response logic or a FIFO) and the TX pin.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_gen.sv | 31 +++
 rtl/uart_tx_ctl.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_ctl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the transmitter state
// encoding plus helpers that derive the baud divider and the width of the
// baud counter from the clock and line rates.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } txState_t;

    // Clock cycles per bit, truncated toward zero.
    function automatic int calcBaudDiv(input int clockRate, input int baudRate);
        return clockRate / baudRate;
    endfunction

    // Smallest width able to hold the values 0..maxCount-1 (never below 1).
    function automatic int cntWidth(input int maxCount);
        int w;
        w = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < maxCount) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: counts 0..BAUD_DIV-1 and flags the final cycle of
// each bit period. A synchronous clear holds the count at zero so a new
// frame always starts on a full-length bit.
module uart_baud_gen #(
    parameter int BAUD_DIV = 10,
    parameter int CNT_W    = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bitEnd
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    // Bit-period counter; wraps on the last cycle of every bit so bits chain without a gap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST_CNT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_bitEnd = (r_cnt == LAST_CNT);

endmodule

// File: rtl/uart_tx_ctl.sv
// UART transmit controller: accepts characters over a valid/ack handshake
// and serialises them LSB first as 8N1 frames on txd_tx. Defining
// UART_TX_PARITY_EN inserts an even-parity bit after the data (8E1).
// Every output comes straight from a flop; next values are decoded from
// the next state so the line changes on the same edge the state does.
module uart_tx_ctl
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 50_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic       clk_tx,
    input  logic       rst_clk_tx_n,
    input  logic [7:0] tx_data,
    input  logic       tx_data_vld,
    output logic       tx_data_ack,
    output logic       tx_busy,
    output logic       txd_tx
);

    localparam int BAUD_DIV = calcBaudDiv(CLOCK_RATE, BAUD_RATE);
    localparam int CNT_W    = cntWidth(BAUD_DIV);

    if (BAUD_DIV < 2) begin : gBaudCheck
        $error("uart_tx_ctl: BAUD_DIV must be at least 2");
    end

    txState_t   r_state;
    txState_t   w_stateNext;
    logic [7:0] r_shift;
    logic [7:0] w_shiftNext;
    logic [2:0] r_bitIdx;
    logic [2:0] w_bitIdxNext;
    logic       r_txd;
    logic       w_txdNext;
    logic       r_ack;
    logic       r_busy;
    logic       w_accept;
    logic       w_bitEnd;
    logic       w_cntClear;
`ifdef UART_TX_PARITY_EN
    logic       r_parity;
    logic       w_parityNext;
`endif

    // The counter idles at zero so the accepting edge starts the start bit on count 0.
    assign w_cntClear = (r_state == ST_IDLE);

    uart_baud_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baudGen (
        .i_clk    (clk_tx),
        .i_rst_n  (rst_clk_tx_n),
        .i_clear  (w_cntClear),
        .o_bitEnd (w_bitEnd)
    );

    // A character is taken when idle, or on the last stop-bit cycle for back-to-back frames.
    assign w_accept = tx_data_vld &&
                      ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bitEnd));

    // Next-state, shift register and bit index decode; line level follows from the next state.
    always_comb begin
        w_stateNext  = r_state;
        w_shiftNext  = r_shift;
        w_bitIdxNext = r_bitIdx;
        w_txdNext    = 1'b1;
`ifdef UART_TX_PARITY_EN
        w_parityNext = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_IDLE;
            end
            ST_START: begin
                if (w_bitEnd) begin
                    w_stateNext = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bitEnd) begin
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_bitIdxNext = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_stateNext  = ST_PARITY;
`else
                        w_stateNext  = ST_STOP;
`endif
                    end else begin
                        w_bitIdxNext = r_bitIdx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bitEnd) begin
                    w_stateNext = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bitEnd) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_stateNext  = ST_START;
            w_shiftNext  = tx_data;
            w_bitIdxNext = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_parityNext = ^tx_data;
`endif
        end

        case (w_stateNext)
            ST_START:  w_txdNext = 1'b0;
            ST_DATA:   w_txdNext = w_shiftNext[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txdNext = w_parityNext;
`endif
            default:   w_txdNext = 1'b1;
        endcase
    end

    // State and registered outputs; reset aborts any frame and returns the line high at once.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            r_state  <= ST_IDLE;
            r_shift  <= 8'd0;
            r_bitIdx <= 3'd0;
            r_txd    <= 1'b1;
            r_ack    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_shift  <= w_shiftNext;
            r_bitIdx <= w_bitIdxNext;
            r_txd    <= w_txdNext;
            r_ack    <= w_accept;
            r_busy   <= (w_stateNext != ST_IDLE);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the captured character, held for the parity bit.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parityNext;
        end
    end
`endif

    assign txd_tx      = r_txd;
    assign tx_data_ack = r_ack;
    assign tx_busy     = r_busy;

endmodule

// File: tb/tb_uart_tx_ctl.sv
// Directed bench for uart_tx_ctl at BAUD_DIV = 10. Frames are checked cycle
// by cycle as {tx_busy, tx_data_ack, txd_tx} against hand-written bit
// patterns (index 0 = start bit). Build with UART_TX_PARITY_EN for the 8E1 cases.
module tb_uart_tx_ctl;

    localparam int CLOCK_RATE = 50_000_000;
    localparam int BAUD_RATE  = 5_000_000;
    localparam int BAUD_DIV   = 10;

    logic       clk_tx;
    logic       rst_clk_tx_n;
    logic [7:0] tx_data;
    logic       tx_data_vld;
    logic       tx_data_ack;
    logic       tx_busy;
    logic       txd_tx;

    int assertCount;
    int failCount;

    uart_tx_ctl #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk_tx       (clk_tx),
        .rst_clk_tx_n (rst_clk_tx_n),
        .tx_data      (tx_data),
        .tx_data_vld  (tx_data_vld),
        .tx_data_ack  (tx_data_ack),
        .tx_busy      (tx_busy),
        .txd_tx       (txd_tx)
    );

    // 100 MHz bench clock; only the cycle count matters to the DUT.
    initial clk_tx = 1'b0;
    always #5 clk_tx = ~clk_tx;

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents a character and waits (bounded) for the ack; returns on the first ack cycle.
    task automatic applyStimulus(input logic [7:0] data);
        bit seen;
        seen        = 1'b0;
        tx_data     = data;
        tx_data_vld = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk_tx);
            #1;
            if (tx_data_ack) seen = 1'b1;
        end
        checkOutput($sformatf("ackSeen_%02h", data), {31'd0, seen}, 32'd1);
    endtask

    // Walks a frame from its first cycle; optionally rewrites tx_data mid-frame.
    task automatic observeFrame(input string tag, input logic [10:0] expBits, input int nCycles,
                                input int changeAt, input logic [7:0] newData);
        for (int k = 0; k < nCycles; k++) begin
            if (k == changeAt) tx_data = newData;
            checkOutput($sformatf("%s[%0d]", tag, k),
                        {29'd0, tx_busy, tx_data_ack, txd_tx},
                        {29'd0, 1'b1, (k == 0), expBits[k / BAUD_DIV]});
            @(posedge clk_tx);
            #1;
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput(tag, {29'd0, tx_busy, tx_data_ack, txd_tx}, 32'd1);
    endtask

    // Watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        assertCount  = 0;
        failCount    = 0;
        rst_clk_tx_n = 1'b0;
        tx_data      = 8'h00;
        tx_data_vld  = 1'b0;

        #12;
        checkIdle("resetState");
        #11;
        rst_clk_tx_n = 1'b1;
        @(posedge clk_tx);
        #1;
        checkIdle("afterReset");

`ifdef UART_TX_PARITY_EN
        // 0x07: start, 1,1,1,0,0,0,0,0, parity 1, stop
        applyStimulus(8'h07);
        tx_data_vld = 1'b0;
        observeFrame("par07", 11'b11000001110, 110, -1, 8'h00);
        checkIdle("par07Idle");

        // 0x55: four ones, so parity 0
        applyStimulus(8'h55);
        tx_data_vld = 1'b0;
        observeFrame("par55", 11'b10010101010, 110, -1, 8'h00);
        checkIdle("par55Idle");
`else
        // 0x55 single frame
        applyStimulus(8'h55);
        tx_data_vld = 1'b0;
        observeFrame("send55", 11'b01010101010, 100, -1, 8'h00);
        checkIdle("send55Idle");

        // Back-to-back 0xA3 then 0x0F with valid held high
        applyStimulus(8'hA3);
        tx_data = 8'h0F;
        observeFrame("b2bA3", 11'b01101000110, 100, -1, 8'h00);
        tx_data_vld = 1'b0;
        observeFrame("b2b0F", 11'b01000011110, 100, -1, 8'h00);
        checkIdle("b2bIdle");

        // tx_data changes after acceptance must not reach the line
        applyStimulus(8'h3C);
        tx_data_vld = 1'b0;
        observeFrame("hold3C", 11'b01001111000, 100, 2, 8'hFF);
        checkIdle("hold3CIdle");

        // Reset in the middle of data bit 4 of 0x6C (line low there)
        applyStimulus(8'h6C);
        tx_data_vld = 1'b0;
        observeFrame("pre6C", 11'b01011011000, 55, -1, 8'h00);
        #2;
        rst_clk_tx_n = 1'b0;
        #1;
        checkIdle("rstAsync");
        repeat (2) @(posedge clk_tx);
        #3;
        rst_clk_tx_n = 1'b1;
        @(posedge clk_tx);
        #1;
        checkIdle("rstRelease");

        applyStimulus(8'h81);
        tx_data_vld = 1'b0;
        observeFrame("send81", 11'b01100000010, 100, -1, 8'h00);
        checkIdle("send81Idle");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
